// File: rtl/shift_pkg.sv
// Shared constants for the shift arbiter: data width and op encoding.
package shift_pkg;
    localparam int XLEN = 32;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;
endpackage

// File: rtl/shift_core.sv
// Combinational 32-bit shifter. The full 32-bit shift amount is honoured:
// any amount >= 32 saturates to all-zero (logical) or all-sign (arithmetic).
module shift_core
    import shift_pkg::*;
(
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] B,
    input  logic [XLEN-1:0] shamt,
    output logic [XLEN-1:0] res
);
    logic       big;
    logic [4:0] sh;

    assign big = |shamt[XLEN-1:5];
    assign sh  = shamt[4:0];

    // select the shift result; saturate when the amount covers the whole word
    always_comb begin
        res = B;
        case (op)
            OP_SLL:  res = big ? '0 : (B << sh);
            OP_SRL:  res = big ? '0 : (B >> sh);
            OP_SRA:  res = big ? {XLEN{B[XLEN-1]}} : XLEN'($signed(B) >>> sh);
            default: res = B;
        endcase
    end
endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift_core among NREQ requesters.
// One-entry registered output slot, drained by resp_valid/resp_ready;
// a new grant may overwrite the slot in the same cycle it drains.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int ID_W = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [XLEN*NREQ-1:0] req_B,
    input  logic [XLEN*NREQ-1:0] req_shamt,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [XLEN-1:0]      resp_res,
    output logic [ID_W-1:0]      resp_id,
    output logic                 busy
);
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] gidx;
    logic [NREQ-1:0] gnt;
    logic            can_accept;
    logic [1:0]      sel_op;
    logic [XLEN-1:0] sel_b;
    logic [XLEN-1:0] sel_s;
    logic [XLEN-1:0] core_res;

    assign can_accept = !resp_valid || resp_ready;
    assign req_ready  = gnt;
    assign busy       = resp_valid || (|req_valid);

    // pick the first valid requester at or after ptr; scanning from the far
    // end lets the closest one overwrite, so no "found" flag is needed
    always_comb begin
        int j;
        j    = 0;
        gnt  = '0;
        gidx = '0;
        if (!rst && can_accept) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                j = int'(ptr) + k;
                if (j >= NREQ) j = j - NREQ;
                if (req_valid[j]) begin
                    gnt    = '0;
                    gnt[j] = 1'b1;
                    gidx   = ID_W'(j);
                end
            end
        end
    end

    // route the granted operand set into the single shared shifter
    always_comb begin
        sel_op = req_op[2*int'(gidx) +: 2];
        sel_b  = req_B[XLEN*int'(gidx) +: XLEN];
        sel_s  = req_shamt[XLEN*int'(gidx) +: XLEN];
    end

    shift_core u_core (
        .op    (sel_op),
        .B     (sel_b),
        .shamt (sel_s),
        .res   (core_res)
    );

    // output slot and round-robin pointer; ptr advances only on a grant
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_res   <= '0;
            resp_id    <= '0;
            ptr        <= '0;
        end else if (|gnt) begin
            resp_valid <= 1'b1;
            resp_res   <= core_res;
            resp_id    <= gidx;
            ptr        <= (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: directed scenarios followed by random
// traffic, checked against an abstract round-robin / shift model.
module tb_shift_arbiter;
    localparam int NREQ = 2;
    localparam int ID_W = 1;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     res;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [2*NREQ-1:0]    req_op;
    logic [32*NREQ-1:0]   req_B;
    logic [32*NREQ-1:0]   req_shamt;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [31:0]          resp_res;
    logic [ID_W-1:0]      resp_id;
    logic                 busy;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   started = 0;

    // model state owned by the stimulus process
    int   m_ptr = 0;
    bit   m_valid = 0;
    bit   rst_prev = 0;

    shift_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_B(req_B), .req_shamt(req_shamt),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_res(resp_res), .resp_id(resp_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
        end
    endtask

    // reference shift: one bit position per iteration, amount capped at 32
    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] b,
                                              input logic [31:0] s);
        logic [31:0] r;
        int n;
        r = b;
        n = (s >= 32) ? 32 : int'(s);
        if (op == 2'b11) return b;
        for (int i = 0; i < n; i++) begin
            case (op)
                2'b00:   r = r * 2;
                2'b01:   r = r / 2;
                default: r = (r / 2) | (b[31] ? 32'h8000_0000 : 32'h0);
            endcase
        end
        return r;
    endfunction

    // one clock of stimulus; model grant is evaluated just before the edge
    task automatic step(input logic [1:0] v, input logic [1:0] op0, input logic [31:0] b0,
                        input logic [31:0] s0, input logic [1:0] op1, input logic [31:0] b1,
                        input logic [31:0] s1, input logic rr, input logic r);
        int g;
        logic [NREQ-1:0] eg;
        logic [1:0]  ops[NREQ];
        logic [31:0] bs[NREQ];
        logic [31:0] ss[NREQ];
        ops[0] = op0; ops[1] = op1;
        bs[0]  = b0;  bs[1]  = b1;
        ss[0]  = s0;  ss[1]  = s1;
        @(negedge clk);
        #1;
        rst        = r;
        req_valid  = v;
        resp_ready = rr;
        req_op     = {op1, op0};
        req_B      = {b1, b0};
        req_shamt  = {s1, s0};
        #3;
        if (rst_prev) begin
            chk("rst_res", resp_res, 32'h0);
            chk("rst_id", 32'(resp_id), 32'h0);
        end
        eg = '0;
        g  = -1;
        if (!r && (!m_valid || rr)) begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_ptr + k) % NREQ;
                if (g < 0 && v[j]) g = j;
            end
        end
        if (g >= 0) eg[g] = 1'b1;
        if (started) chk("req_ready", 32'(req_ready), 32'(eg));
        if (r) begin
            q.delete();
            m_valid = 0;
            m_ptr   = 0;
        end else if (g >= 0) begin
            q.push_back('{id: ID_W'(g), res: ref_shift(ops[g], bs[g], ss[g])});
            m_ptr   = (g + 1) % NREQ;
            m_valid = 1;
        end else if (rr) begin
            m_valid = 0;
        end
        rst_prev = r;
        if (r) started = 1;
    endtask

    // monitor: checks the output slot against the scoreboard head each cycle
    // and retires the head on a completed handshake
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (started && !rst_prev) begin
                chk("resp_valid", 32'(resp_valid), 32'(q.size() != 0));
                chk("busy", 32'(busy), 32'((q.size() != 0) || (|req_valid)));
                if (resp_valid && q.size() != 0) begin
                    chk("resp_res", resp_res, q[0].res);
                    chk("resp_id", 32'(resp_id), 32'(q[0].id));
                    if (resp_ready && !rst) void'(q.pop_front());
                end
            end
        end
    end

    function automatic logic [31:0] rnd_s();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd31;
            2: return 32'd32;
            3: return 32'hFFFF_FFFF;
            4: return $urandom;
            default: return 32'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        rst = 1'b1; req_valid = '0; resp_ready = 1'b0;
        req_op = '0; req_B = '0; req_shamt = '0;

        step(2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
        step(2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
        step(2'b00, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);

        // single op
        step(2'b01, 2'b00, 32'h1, 32'd4, 0, 0, 0, 1'b1, 1'b0);
        step(2'b00, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);

        // boundary shifts
        step(2'b01, 2'b10, 32'h8000_0000, 32'd31, 0, 0, 0, 1'b1, 1'b0);
        step(2'b01, 2'b10, 32'h8000_0000, 32'd32, 0, 0, 0, 1'b1, 1'b0);
        step(2'b01, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 1'b1, 1'b0);
        step(2'b01, 2'b01, 32'h8000_0000, 32'd32, 0, 0, 0, 1'b1, 1'b0);
        step(2'b01, 2'b00, 32'h1234_5678, 32'd0, 0, 0, 0, 1'b1, 1'b0);
        step(2'b01, 2'b11, 32'hCAFE_F00D, 32'd7, 0, 0, 0, 1'b1, 1'b0);
        step(2'b00, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);

        // fairness: both valid for 6 cycles
        for (int i = 0; i < 6; i++)
            step(2'b11, 2'b00, 32'h3 + i, 32'd1, 2'b01, 32'hF0 + i, 32'd2, 1'b1, 1'b0);
        step(2'b00, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);

        // backpressure: hold slot 3 cycles while req1 waits
        step(2'b01, 2'b00, 32'h5, 32'd3, 0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(2'b10, 0, 0, 0, 2'b10, 32'hF000_0000, 32'd4, 1'b0, 1'b0);
        step(2'b10, 0, 0, 0, 2'b10, 32'hF000_0000, 32'd4, 1'b1, 1'b0);
        step(2'b00, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);

        // reset mid-operation; req0 served first so ptr points at req1
        step(2'b01, 2'b00, 32'h9, 32'd1, 0, 0, 0, 1'b0, 1'b0);
        step(2'b11, 2'b00, 32'h9, 32'd1, 2'b00, 32'h7, 32'd1, 1'b0, 1'b1);
        step(2'b11, 2'b00, 32'h9, 32'd1, 2'b00, 32'h7, 32'd1, 1'b1, 1'b0);
        chk("post_rst_grant", 32'(req_ready), 32'h1);
        step(2'b00, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);

        // random traffic
        for (int i = 0; i < 600; i++)
            step(2'($urandom), 2'($urandom), $urandom, rnd_s(),
                 2'($urandom), $urandom, rnd_s(),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0));
        for (int i = 0; i < 3; i++)
            step(2'b00, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
